// File: rtl/seq_det_pkg.sv
// Shared types and reset-default configuration for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        MODE_MEALY = 1'b0,
        MODE_MOORE = 1'b1
    } mode_e;

    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_LEN     = 4;
    localparam logic       DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment restarts the count at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with Mealy/Moore output,
// optional overlap, and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cfg_moore,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

    // Only the newest PAT_W-1 past bits are ever compared; the current x completes the window.
    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    mode_e            mode_r;
    logic             moore_q;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             len_ok;
    logic             match;

    always_comb begin
        window = {hist, x};
        // Shifting by the full width yields 0, so the subtraction wraps to all ones.
        mask   = (PAT_W'(1) << len_r) - PAT_W'(1);
        len_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= FULL);
        match  = en && !cfg_load && (fill >= len_r - LEN_W'(1))
                 && ((window & mask) == (pat_r & mask));
        y      = (mode_r == MODE_MOORE) ? moore_q : match;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_r  <= PAT_W'(DEF_PATTERN);
            len_r  <= LEN_W'(DEF_LEN);
            ovl_r  <= DEF_OVERLAP;
            mode_r <= MODE_MEALY;
        end else if (cfg_load && len_ok) begin
            pat_r  <= cfg_pattern;
            len_r  <= cfg_len;
            ovl_r  <= cfg_overlap;
            mode_r <= mode_e'(cfg_moore);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (cfg_load) begin
            if (len_ok) begin
                hist <= '0;
                fill <= '0;
            end
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            if (match && !ovl_r) begin
                fill <= '0;
            end else if (fill != FULL) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

    // A cfg_load cycle never matches, so it also drops any pending Moore pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            moore_q <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            moore_q <= match;
            if (cfg_load && !len_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_seq_detector_param;

    localparam int PAT_W   = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(PAT_W + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             x = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cfg_moore = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the sampled bit stream as a queue, oldest first.
    int               m_bits[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_moore;
    bit               m_mq;
    bit               m_err;
    int               m_cnt;

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .cnt_clr     (cnt_clr),
        .y           (y),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat   = 8'b0000_1011;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_moore = 1'b0;
        m_mq    = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // The last m_len-1 sampled bits followed by x must spell the pattern MSB first.
    function automatic bit model_match();
        int base;
        if (!en || cfg_load) return 1'b0;
        if (m_bits.size() < m_len - 1) return 1'b0;
        base = m_bits.size() - (m_len - 1);
        for (int i = 0; i < m_len - 1; i++)
            if (m_bits[base + i] != int'(m_pat[m_len - 1 - i])) return 1'b0;
        return x == m_pat[0];
    endfunction

    // Inputs change just after posedge, so at negedge they hold the values the next edge samples.
    always @(negedge clk) begin
        bit mt;
        if (!reset) begin
            model_reset();
            chk("y_in_reset", y, 0);
            chk("cnt_in_reset", match_cnt, 0);
            chk("err_in_reset", cfg_err, 0);
        end else begin
            mt = model_match();
            chk("model_y", y, m_moore ? m_mq : mt);
            chk("model_cnt", match_cnt, m_cnt);
            chk("model_err", cfg_err, m_err);
            if (cfg_load) begin
                if (cfg_len >= 2 && cfg_len <= PAT_W) begin
                    m_pat   = cfg_pattern;
                    m_len   = int'(cfg_len);
                    m_ovl   = cfg_overlap;
                    m_moore = cfg_moore;
                    m_bits.delete();
                end else begin
                    m_err = 1'b1;
                end
            end else if (en) begin
                if (mt && !m_ovl) begin
                    m_bits.delete();
                end else begin
                    m_bits.push_back(int'(x));
                    if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                end
            end
            m_mq = mt;
            if (cnt_clr) m_cnt = mt ? 1 : 0;
            else if (mt && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en = 1'b0;
        cfg_load = 1'b0;
        cnt_clr = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Send n bits MSB first, checking y against the matching bit of yexp before each edge.
    task automatic send_seq(input string tag, input logic [31:0] bits, input int n,
                            input logic [31:0] yexp);
        for (int i = n - 1; i >= 0; i--) begin
            en = 1'b1;
            x  = bits[i];
            @(negedge clk);
            chk(tag, y, yexp[i]);
            tick();
        end
        en = 1'b0;
    endtask

    task automatic do_cfg(input logic [PAT_W-1:0] pat, input int len, input logic ovl,
                          input logic moore, input logic with_en);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_moore   = moore;
        en          = with_en;
        x           = 1'b1;
        @(negedge clk);
        if (with_en) chk("cfg_beats_en_y", y, 0);
        tick();
        cfg_load = 1'b0;
        en       = 1'b0;
    endtask

    initial begin
        int exp_cnt[5];
        exp_cnt = '{1, 2, 3, 3, 3};

        do_reset();

        // Default pattern 1011, Mealy
        send_seq("def_1011_y", 32'b1011, 4, 32'b0001);
        chk("def_1011_cnt", match_cnt, 1);

        // Overlapping then non-overlapping on 1011011
        do_reset();
        send_seq("ovl_y", 32'b1011011, 7, 32'b0001001);
        chk("ovl_cnt", match_cnt, 2);
        do_cfg(8'b0000_1011, 4, 1'b0, 1'b0, 1'b0);
        send_seq("novl_y", 32'b1011011, 7, 32'b0001000);
        chk("novl_cnt_sat", match_cnt, 3);

        // Full-width Moore pattern: pulse only on the cycle after the 8th edge
        do_cfg(8'b1100_1101, 8, 1'b1, 1'b1, 1'b0);
        send_seq("moore_bits_y", 32'b1100_1101, 8, 32'b0);
        @(negedge clk);
        chk("moore_pulse", y, 1);
        tick();
        @(negedge clk);
        chk("moore_pulse_end", y, 0);
        tick();

        // en gaps hold history
        do_reset();
        send_seq("gap_pre_y", 32'b10, 2, 32'b00);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0;
            x  = 1'b1;
            @(negedge clk);
            chk("gap_hold_y", y, 0);
            tick();
        end
        send_seq("gap_post_y", 32'b11, 2, 32'b01);

        // Counter saturation at CNT_W=2, then clear with coincident match
        do_reset();
        send_seq("sat_first_y", 32'b1011, 4, 32'b0001);
        chk("sat_cnt_0", match_cnt, exp_cnt[0]);
        for (int k = 1; k < 5; k++) begin
            send_seq("sat_more_y", 32'b011, 3, 32'b001);
            chk("sat_cnt_k", match_cnt, exp_cnt[k]);
        end
        send_seq("clr_pre_y", 32'b01, 2, 32'b00);
        en = 1'b1;
        x = 1'b1;
        cnt_clr = 1'b1;
        tick();
        en = 1'b0;
        cnt_clr = 1'b0;
        chk("clr_with_match_cnt", match_cnt, 1);

        // Illegal lengths leave config and history alone and set the sticky error
        do_reset();
        send_seq("bad_pre_y", 32'b101, 3, 32'b000);
        do_cfg(8'hFF, 1, 1'b0, 1'b1, 1'b0);
        chk("bad_len1_err", cfg_err, 1);
        send_seq("bad_hist_kept_y", 32'b1, 1, 32'b1);
        do_cfg(8'h00, 9, 1'b0, 1'b1, 1'b0);
        chk("bad_len9_err", cfg_err, 1);

        // cfg_load in the same cycle as en: bit discarded, history cleared
        send_seq("both_pre_y", 32'b101, 3, 32'b000);
        do_cfg(8'b0000_1011, 4, 1'b1, 1'b0, 1'b1);
        send_seq("both_post_y", 32'b1011, 4, 32'b0001);

        // Reset mid-sequence discards the partial match and the sticky error
        send_seq("rst_pre_y", 32'b101, 3, 32'b000);
        do_reset();
        chk("rst_err_clear", cfg_err, 0);
        send_seq("rst_single_y", 32'b1, 1, 32'b0);
        send_seq("rst_full_y", 32'b011, 3, 32'b001);

        // Mixed traffic under several configurations, checked by the model only
        for (int c = 0; c < 5; c++) begin
            do_cfg(PAT_W'($urandom_range(0, 255)), $urandom_range(2, PAT_W),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 150; i++) begin
                en      = ($urandom_range(0, 9) < 7);
                x       = 1'($urandom_range(0, 1));
                cnt_clr = ($urandom_range(0, 39) == 0);
                tick();
            end
            en = 1'b0;
            cnt_clr = 1'b0;
        end
        // Short patterns make matches frequent enough to reach saturation
        do_cfg(8'b0000_0011, 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            en = 1'b1;
            x  = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        en = 1'b0;

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match counter width.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  x is sampled on a rising edge only when en=1.
REQ-006 x  input  1  serial data bit.
REQ-007 cfg_load  input  1  strobe that latches cfg_pattern, cfg_len, cfg_overlap and cfg_moore.
REQ-008 cfg_pattern  input  PAT_W  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-009 cfg_len  input  $clog2(PAT_W+1)  active pattern length, legal range 2..PAT_W.
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 cfg_moore  input  1  1 = registered (Moore) output, 0 = combinational (Mealy) output.
REQ-012 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-013 y  output  1  match pulse.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.
REQ-015 cfg_err  output  1  sticky flag: a cfg_load was issued with an illegal cfg_len.

Function
REQ-016 A history register holds the last PAT_W sampled bits. A fill counter saturates at PAT_W.
REQ-017 When en=1, a match condition exists if fill >= cfg_len-1 and {history[cfg_len-2:0], x} equals cfg_pattern[cfg_len-1:0].
REQ-018 Mealy mode: y = en AND match condition, combinationally, in the same cycle as the final pattern bit.
REQ-019 Moore mode: y is registered. It is 1 for exactly one cycle following the rising edge at which the match condition held, independent of en.
REQ-020 In both modes, y is never 1 unless a match condition has occurred.
REQ-021 Overlap mode: on a match, the history shifts normally.
REQ-022 Non-overlap mode: on a match, fill clears to 0, so the next match needs cfg_len fresh bits.
REQ-023 When en=0, history, fill and the Moore pending state hold. Mealy y=0.
REQ-024 On every match edge, match_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
REQ-025 If cnt_clr and a match occur on the same edge, match_cnt becomes 1.
REQ-026 cfg_load with a legal cfg_len:
 - latches all four configuration inputs;
 - clears fill and history;
 - clears a pending Moore y;
 - leaves match_cnt unchanged.
REQ-027 cfg_load with cfg_len<2 or cfg_len>PAT_W: configuration is unchanged, history is unchanged, cfg_err is set.
REQ-028 When cfg_load and en=1 occur in the same cycle, cfg_load wins. The bit is discarded, there is no match, and Mealy y=0.
REQ-029 cfg_err clears only on reset.
REQ-030 Configuration changes take effect from the cycle after cfg_load.

Reset
REQ-031 Assertion of reset (low) immediately forces:
 - y=0, match_cnt=0, cfg_err=0;
 - history=0, fill=0;
 - pattern = zero-extended 4'b1011, length=4, overlap=1, mode=Mealy.
REQ-032 Reset asserted mid-sequence discards partial matches. The first match after release needs a full cfg_len bits.
REQ-033 Deassertion is synchronised by the integrating design; the block adds no synchroniser.

Structure
REQ-034 Package seq_det_pkg holds:
 - output mode enum {MODE_MEALY, MODE_MOORE};
 - reset-default constants DEF_PATTERN=4'b1011, DEF_LEN=4, DEF_OVERLAP=1.
REQ-035 The saturating counter is a sub-module, sat_counter, parameterised by width, with inc and clr inputs.
REQ-036 All sequential logic is on the clk rising edge or the reset falling edge. There are no latches.

Verification
REQ-037 Reset defaults, Mealy mode, en=1, x stream 1,0,1,1 -> y=1 combinationally during the 4th bit; match_cnt=1 after that edge.
REQ-038 Default mode, stream 1,0,1,1,0,1,1 -> y high on bits 4 and 7 (overlap); match_cnt=2. Same stream with cfg_overlap=0, len=4 -> y high on bit 4 only.
REQ-039 cfg_load pattern 8'b11001101, len=8, Moore; stream 1,1,0,0,1,1,0,1 -> y=1 for exactly the one cycle after the 8th edge.
REQ-040 Default mode; en=0 for 3 cycles inserted between bits 2 and 3 of 1,0,1,1 -> y=0 while en=0; match still detected on the 4th bit.
REQ-041 CNT_W=2; drive 5 matches -> match_cnt reads 1,2,3,3,3. Then cnt_clr together with a match -> match_cnt=1.
REQ-042 Two cases:
 - cfg_load with cfg_len=1 -> cfg_err=1 and configuration unchanged.
 - Reset asserted after bits 1,0,1 -> a following single 1 gives y=0.
